// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder.
//   op_t   : operation select (ADD, SUB, ADDSAT, SUBSAT)
//   is_sub : true for the subtracting operations (operand B inverted, borrow convention)
package adder_pkg;

    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        ADDSAT = 2'd2,
        SUBSAT = 2'd3
    } op_t;

    function automatic logic is_sub(op_t op);
        return (op == SUB) || (op == SUBSAT);
    endfunction

endpackage

// File: rtl/adder_slice_stage.sv
// One pipeline stage of the sliced adder: adds the lowest SLICE bits of the (pre-shifted)
// operands plus the incoming carry, and registers the sum slice, carry-out, op, valid and the
// remaining operand bits. Operands are shifted down by SLICE each stage so every stage works on
// bits [SLICE-1:0]; the partial result is shifted down and the new slice inserted at the top, so
// after the last stage slice 0 sits at the bottom. The last stage also applies saturation.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : global advance; when low no register changes
//   valid_i/op_i/a_i/b_i/c_i/res_i : stage inputs (b_i already inverted for subtraction)
//   valid_o/op_o/a_o/b_o/c_o/res_o : registered stage outputs
module adder_slice_stage
    import adder_pkg::*;
#(
    parameter int unsigned SLICE      = 4,
    parameter int unsigned DATASIZE   = 8,
    parameter bit          LAST_STAGE = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                valid_i,
    input  op_t                 op_i,
    input  logic [DATASIZE-1:0] a_i,
    input  logic [DATASIZE-1:0] b_i,
    input  logic                c_i,
    input  logic [DATASIZE-1:0] res_i,
    output logic                valid_o,
    output op_t                 op_o,
    output logic [DATASIZE-1:0] a_o,
    output logic [DATASIZE-1:0] b_o,
    output logic                c_o,
    output logic [DATASIZE-1:0] res_o
);

    logic [SLICE:0]        sum;
    logic [DATASIZE-1:0]   a_shift;
    logic [DATASIZE-1:0]   b_shift;
    logic [DATASIZE-1:0]   res_merged;
    logic [DATASIZE-1:0]   res_d;

    logic                  valid_q;
    op_t                   op_q;
    logic [DATASIZE-1:0]   a_q;
    logic [DATASIZE-1:0]   b_q;
    logic                  c_q;
    logic [DATASIZE-1:0]   res_q;

    assign sum = {1'b0, a_i[SLICE-1:0]} + {1'b0, b_i[SLICE-1:0]} + {{SLICE{1'b0}}, c_i};

    if (SLICE < DATASIZE) begin : g_merge
        // Bottom slice of res_i has already been consumed by the shift; drop it.
        logic unused_res;
        assign unused_res = ^res_i[SLICE-1:0];
        assign res_merged = {sum[SLICE-1:0], res_i[DATASIZE-1:SLICE]};
        assign a_shift    = {{SLICE{1'b0}}, a_i[DATASIZE-1:SLICE]};
        assign b_shift    = {{SLICE{1'b0}}, b_i[DATASIZE-1:SLICE]};
    end else begin : g_full
        // Single full-width stage: nothing to merge or carry forward.
        logic unused_res;
        assign unused_res = ^res_i;
        assign res_merged = sum[SLICE-1:0];
        assign a_shift    = '0;
        assign b_shift    = '0;
    end

    // Saturation uses the raw final carry; sum[SLICE] is c_N only in the last stage.
    always_comb begin
        res_d = res_merged;
        if (LAST_STAGE) begin
            if (op_i == ADDSAT && sum[SLICE]) begin
                res_d = '1;
            end else if (op_i == SUBSAT && !sum[SLICE]) begin
                res_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            op_q    <= ADD;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            op_q    <= op_i;
            a_q     <= a_shift;
            b_q     <= b_shift;
            c_q     <= sum[SLICE];
            res_q   <= res_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign c_o     = c_q;
    assign res_o   = res_q;

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined add/sub with optional unsigned saturation. The operand is split into NB_STAGES
// slices and the carry ripples one slice per clock; latency is NB_STAGES cycles, throughput one
// transaction per cycle. A single global advance signal stalls the whole pipeline when the
// output is held (bubbles are not collapsed).
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   valid_i, ready_o       : input handshake
//   op_i, a_i, b_i         : operation and unsigned operands
//   carryin_i              : carry-in (ADD*) / borrow-in (SUB*)
//   valid_o, ready_i       : output handshake
//   result_o               : (saturated) result
//   carryout_o             : raw carry-out (ADD*) / borrow-out (SUB*)
module adder_pipelined
    import adder_pkg::*;
#(
    parameter int unsigned DATASIZE  = 8,
    parameter int unsigned NB_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  op_t                 op_i,
    input  logic [DATASIZE-1:0] a_i,
    input  logic [DATASIZE-1:0] b_i,
    input  logic                carryin_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DATASIZE-1:0] result_o,
    output logic                carryout_o
);

    localparam int unsigned SAFE_STAGES = (NB_STAGES == 0) ? 1 : NB_STAGES;
    localparam int unsigned SLICE       = DATASIZE / SAFE_STAGES;

    if (NB_STAGES < 1 || (DATASIZE % SAFE_STAGES) != 0) begin : g_bad_params
        $error("adder_pipelined: DATASIZE must be divisible by NB_STAGES and NB_STAGES >= 1");
    end

    // Index k holds the inputs of stage k; index NB_STAGES holds the last stage's registers.
    logic                valid_s [0:NB_STAGES];
    op_t                 op_s    [0:NB_STAGES];
    logic [DATASIZE-1:0] a_s     [0:NB_STAGES];
    logic [DATASIZE-1:0] b_s     [0:NB_STAGES];
    logic                c_s     [0:NB_STAGES];
    logic [DATASIZE-1:0] res_s   [0:NB_STAGES];

    logic adv;
    logic sub_in;

    assign adv     = ready_i || !valid_o;
    assign ready_o = adv;

    // Subtraction as a + ~b + ~borrow: carry-out 1 means no borrow.
    assign sub_in     = is_sub(op_i);
    assign valid_s[0] = valid_i;
    assign op_s[0]    = op_i;
    assign a_s[0]     = a_i;
    assign b_s[0]     = sub_in ? ~b_i : b_i;
    assign c_s[0]     = sub_in ^ carryin_i;
    assign res_s[0]   = '0;

    for (genvar k = 0; k < NB_STAGES; k++) begin : g_stage
        adder_slice_stage #(
            .SLICE      (SLICE),
            .DATASIZE   (DATASIZE),
            .LAST_STAGE (k == NB_STAGES - 1)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (adv),
            .valid_i (valid_s[k]),
            .op_i    (op_s[k]),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .c_i     (c_s[k]),
            .res_i   (res_s[k]),
            .valid_o (valid_s[k+1]),
            .op_o    (op_s[k+1]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .c_o     (c_s[k+1]),
            .res_o   (res_s[k+1])
        );
    end

    // All operand bits are consumed by the time they leave the last stage.
    logic unused_ops;
    assign unused_ops = ^{a_s[NB_STAGES], b_s[NB_STAGES]};

    assign valid_o    = valid_s[NB_STAGES];
    assign result_o   = res_s[NB_STAGES];
    assign carryout_o = is_sub(op_s[NB_STAGES]) ? ~c_s[NB_STAGES] : c_s[NB_STAGES];

endmodule
